// File: rtl/wrresp_return_channel_pkg.sv
// Shared types and constants for the write-response return channel:
// request/response type codes, FSM states and the pending-entry layout.
package wrresp_return_channel_pkg;

  // Field layout of the TX1 request header
  localparam int TX_META_TYPE_HI = 55;
  localparam int TX_META_TYPE_LO = 52;
  localparam int PEND_MDATA_W    = 16;
  localparam int TS_W            = 32;

  // TX1 request type codes (write-channel request encodings)
  localparam logic [3:0] ASE_TX1_WRTHRU  = 4'h1;
  localparam logic [3:0] ASE_TX1_WRLINE  = 4'h2;
  localparam logic [3:0] ASE_TX1_WRFENCE = 4'h5;

  // RX1 response type codes
  localparam logic [3:0] ASE_RX1_WRITE_RESP   = 4'h1;
  localparam logic [3:0] ASE_RX1_WRFENCE_RESP = 4'h4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FENCE_WAIT = 2'd1,
    PRESENT    = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic [TS_W-1:0]         ts;
    logic                    is_fence;
    logic [PEND_MDATA_W-1:0] mdata;
  } pend_entry_t;

  // Age of an entry in cycles; modular subtraction makes counter wrap transparent.
  function automatic logic [TS_W-1:0] age_of(input logic [TS_W-1:0] now,
                                             input logic [TS_W-1:0] ts);
    return now - ts;
  endfunction

endpackage

// File: rtl/wrresp_return_channel_if.sv
// Request/response handshake bundle between the write-channel output,
// the response generator and the RX1 response consumer.
interface wrresp_return_channel_if #(
  parameter int HDR_WIDTH   = 61,
  parameter int MDATA_WIDTH = 16
);
  logic                   req_valid;
  logic [HDR_WIDTH-1:0]   req_meta;
  logic                   req_full;
  logic                   resp_valid;
  logic [3:0]             resp_type;
  logic [MDATA_WIDTH-1:0] resp_mdata;
  logic                   resp_ready;

  // Side that issues requests and consumes responses
  modport master (
    output req_valid, req_meta, resp_ready,
    input  req_full, resp_valid, resp_type, resp_mdata
  );

  // Side that accepts requests and produces responses
  modport slave (
    input  req_valid, req_meta, resp_ready,
    output req_full, resp_valid, resp_type, resp_mdata
  );
endinterface

// File: rtl/wrresp_return_channel_pending_fifo.sv
// Show-ahead FIFO of pending write/fence entries. Pushes into a full FIFO
// are dropped and flagged; pops of an empty FIFO are ignored and flagged.
module resp_pending_fifo
  import wrresp_return_channel_pkg::*;
#(
  parameter int DEPTH_BASE2 = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  pend_entry_t          push_data,
  input  logic                 pop,
  output pend_entry_t          head,
  output logic                 head_valid,
  output logic [DEPTH_BASE2:0] count,
  output logic [DEPTH_BASE2:0] count_next,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << DEPTH_BASE2;
  localparam logic [DEPTH_BASE2:0]   FULL_COUNT = {1'b1, {DEPTH_BASE2{1'b0}}};
  localparam logic [DEPTH_BASE2-1:0] PTR_ONE    = DEPTH_BASE2'(1);
  localparam logic [DEPTH_BASE2:0]   CNT_ONE    = (DEPTH_BASE2 + 1)'(1);

  pend_entry_t mem_q [DEPTH];

  logic [DEPTH_BASE2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BASE2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BASE2:0]   count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   full_s, empty_s, push_ok_s, pop_ok_s;

  // Next-state pointers, occupancy and sticky error flags.
  always_comb begin
    full_s      = (count_q == FULL_COUNT);
    empty_s     = (count_q == '0);
    push_ok_s   = push && !full_s;
    pop_ok_s    = pop && !empty_s;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (push & full_s);
    underflow_d = underflow_q | (pop & empty_s);
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control registers: pointers, occupancy and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = !empty_s;
  assign count      = count_q;
  assign count_next = count_d;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: rtl/wrresp_return_channel.sv
// Write-response return channel: queues accepted write/fence requests and
// returns RX1 responses in acceptance order. Writes respond after an
// emulated memory latency; a fence reaches the head only after every older
// write has been answered, then waits a fixed fence latency.
module wrresp_return_channel
  import wrresp_return_channel_pkg::*;
#(
  parameter int HDR_WIDTH     = 61,
  parameter int MDATA_WIDTH   = 16,
  parameter int DEPTH_BASE2   = 6,
  parameter int FULL_THRESH   = 56,
  parameter int RESP_LATENCY  = 20,
  parameter int FENCE_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  wrresp_return_channel_if.slave   bus,
  output logic [DEPTH_BASE2:0]     count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int FENCE_CNT_W = (FENCE_LATENCY > 0) ? $clog2(FENCE_LATENCY + 1) : 1;
  localparam logic [FENCE_CNT_W-1:0] FENCE_LOAD = FENCE_CNT_W'(FENCE_LATENCY);
  localparam logic [FENCE_CNT_W-1:0] FENCE_ONE  = FENCE_CNT_W'(1);
  localparam logic [TS_W-1:0]        RESP_AGE   = TS_W'(RESP_LATENCY);
  localparam logic [DEPTH_BASE2:0]   FULL_LVL   = (DEPTH_BASE2 + 1)'(FULL_THRESH);

  resp_state_e            state_q, state_d;
  logic [TS_W-1:0]        now_q, now_d;
  logic [FENCE_CNT_W-1:0] fence_cnt_q, fence_cnt_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [3:0]             resp_type_q, resp_type_d;
  logic [MDATA_WIDTH-1:0] resp_mdata_q, resp_mdata_d;
  logic                   req_full_q, req_full_d;

  logic [HDR_WIDTH-1:0]   meta_s;
  pend_entry_t            push_entry_s;
  pend_entry_t            head_s;
  logic                   head_valid_s;
  logic                   pop_s;
  logic [TS_W-1:0]        age_s;
  logic [DEPTH_BASE2:0]   count_s, count_next_s;

  assign meta_s = bus.req_meta;

  // Build the pending entry for an incoming request, stamped with the current cycle.
  always_comb begin
    push_entry_s          = '0;
    push_entry_s.ts       = now_q;
    push_entry_s.is_fence = (meta_s[TX_META_TYPE_HI:TX_META_TYPE_LO] == ASE_TX1_WRFENCE);
    push_entry_s.mdata    = meta_s[PEND_MDATA_W-1:0];
  end

  resp_pending_fifo #(
    .DEPTH_BASE2 (DEPTH_BASE2)
  ) u_pending (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.req_valid),
    .push_data  (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .head_valid (head_valid_s),
    .count      (count_s),
    .count_next (count_next_s),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  assign age_s = age_of(now_q, head_s.ts);

  // Response FSM next state plus output-register loads, head pop and full flag.
  always_comb begin
    state_d      = state_q;
    fence_cnt_d  = fence_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_type_d  = resp_type_q;
    resp_mdata_d = resp_mdata_q;
    pop_s        = 1'b0;
    now_d        = now_q + 32'd1;
    req_full_d   = (count_next_s >= FULL_LVL);
    case (state_q)
      IDLE: begin
        if (head_valid_s && head_s.is_fence) begin
          fence_cnt_d = FENCE_LOAD;
          state_d     = FENCE_WAIT;
        end else if (head_valid_s && (age_s >= RESP_AGE)) begin
          resp_valid_d = 1'b1;
          resp_type_d  = ASE_RX1_WRITE_RESP;
          resp_mdata_d = head_s.mdata;
          state_d      = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      FENCE_WAIT: begin
        if (fence_cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_type_d  = ASE_RX1_WRFENCE_RESP;
          resp_mdata_d = head_s.mdata;
          state_d      = PRESENT;
        end else begin
          fence_cnt_d = fence_cnt_q - FENCE_ONE;
        end
      end
      PRESENT: begin
        if (bus.resp_ready) begin
          pop_s        = 1'b1;
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State, cycle counter, fence timer and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      now_q        <= '0;
      fence_cnt_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_type_q  <= 4'h0;
      resp_mdata_q <= '0;
      req_full_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      now_q        <= now_d;
      fence_cnt_q  <= fence_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_type_q  <= resp_type_d;
      resp_mdata_q <= resp_mdata_d;
      req_full_q   <= req_full_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_type  = resp_type_q;
  assign bus.resp_mdata = resp_mdata_q;
  assign bus.req_full   = req_full_q;
  assign count          = count_s;

endmodule

// File: tb/tb_wrresp_return_channel.sv
// Scoreboard bench for wrresp_return_channel: directed requests push their
// expected responses; a negedge monitor pops and compares on each handshake.
module tb_wrresp_return_channel;
  import wrresp_return_channel_pkg::*;

  localparam int T = 10;

  typedef struct {
    logic [3:0]  typ;
    logic [15:0] mdata;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic       prev_hs = 1'b0;
  logic       hs_m;

  wrresp_return_channel_if bus_if ();

  wrresp_return_channel dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus_if),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #(T/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [60:0] mk_meta(input logic [3:0] typ, input logic [15:0] md);
    logic [60:0] m;
    m = '0;
    m[TX_META_TYPE_HI:TX_META_TYPE_LO] = typ;
    m[15:0] = md;
    return m;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; the expected response is queued when it will be accepted.
  task automatic send(input logic [3:0] typ, input logic [15:0] md, input bit accept);
    exp_t e;
    bus_if.req_valid = 1'b1;
    bus_if.req_meta  = mk_meta(typ, md);
    if (accept) begin
      e.typ   = (typ == ASE_TX1_WRFENCE) ? ASE_RX1_WRFENCE_RESP : ASE_RX1_WRITE_RESP;
      e.mdata = md;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (bus_if.resp_valid) break;
    end
    checks++;
    if (!bus_if.resp_valid) begin
      errors++;
      $display("FAIL %s timeout actual=no resp_valid required=resp_valid within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_hs(input string name, input logic [15:0] md, input int limit, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      seen = bus_if.resp_valid && bus_if.resp_ready && (bus_if.resp_mdata == md);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout actual=no handshake required=handshake mdata 0x%0h", name, md);
    end
  endtask

  task automatic wait_count0(input string name, input int limit);
    int n;
    n = 0;
    while (n < limit && count != 7'd0) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(count), 32'd0);
  endtask

  // Monitor: compare each accepted response against the scoreboard head.
  always @(negedge clk) begin
    hs_m = rst_n && bus_if.resp_valid && bus_if.resp_ready;
    if (prev_hs) begin
      check("valid_drops_after_pop", 32'(bus_if.resp_valid), 32'd0);
    end
    if (hs_m) begin
      check("underflow_clear", 32'(underflow), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=mdata 0x%0h required=no response", bus_if.resp_mdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_type", 32'(bus_if.resp_type), 32'(mon_e.typ));
        check("resp_mdata", 32'(bus_if.resp_mdata), 32'(mon_e.mdata));
      end
    end
    prev_hs = hs_m;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    int bad;
    int first_full;
    rst_n = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_meta   = '0;
    bus_if.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("rst_resp_type", 32'(bus_if.resp_type), 32'd0);
    check("rst_resp_mdata", 32'(bus_if.resp_mdata), 32'd0);
    check("rst_req_full", 32'(bus_if.req_full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    rst_n = 1'b1;
    sync();

    // Single write: response visible RESP_LATENCY+1 cycles after the request cycle.
    bus_if.resp_ready = 1'b1;
    send(ASE_TX1_WRLINE, 16'h0011, 1'b1);
    wait_valid("t1_wait", 40, n);
    check("t1_latency", 32'(n), 32'd21);
    repeat (3) sync();

    // Two writes then a fence on consecutive cycles.
    send(ASE_TX1_WRLINE, 16'h0001, 1'b1);
    send(ASE_TX1_WRTHRU, 16'h0002, 1'b1);
    send(ASE_TX1_WRFENCE, 16'h0003, 1'b1);
    wait_hs("t2_b_pop", 16'h0002, 60, n);
    wait_valid("t2_fence_wait", 40, n2);
    check("t2_fence_type", 32'(bus_if.resp_type), 32'(ASE_RX1_WRFENCE_RESP));
    check("t2_fence_gap_ge_latency", 32'(n2 >= 4), 32'd1);
    wait_count0("t2_drain", 20);
    sync();

    // Back-pressure: head held stable while resp_ready is low.
    bus_if.resp_ready = 1'b0;
    send(ASE_TX1_WRLINE, 16'h0021, 1'b1);
    send(ASE_TX1_WRLINE, 16'h0022, 1'b1);
    send(ASE_TX1_WRLINE, 16'h0023, 1'b1);
    wait_valid("t3_wait", 40, n);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus_if.resp_valid || bus_if.resp_mdata != 16'h0021) bad++;
    end
    check("t3_hold_stable", 32'(bad), 32'd0);
    check("t3_count", 32'(count), 32'd3);
    sync();
    bus_if.resp_ready = 1'b1;
    wait_count0("t3_drain", 40);
    sync();

    // Fill to 64: req_full at 56, 65th request dropped with overflow.
    bus_if.resp_ready = 1'b0;
    bad = 0;
    first_full = -1;
    for (int i = 0; i < 64; i++) begin
      send(ASE_TX1_WRLINE, 16'h0100 + 16'(i), 1'b1);
      if (count != 7'(i + 1)) bad++;
      if (bus_if.req_full != ((i + 1) >= 56)) bad++;
      if (bus_if.req_full && first_full < 0) first_full = i + 1;
    end
    check("t4_fill_track", 32'(bad), 32'd0);
    check("t4_full_rise_count", 32'(first_full), 32'd56);
    check("t4_no_overflow_yet", 32'(overflow), 32'd0);
    send(ASE_TX1_WRLINE, 16'h01FF, 1'b0);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_count_full", 32'(count), 32'd64);
    bus_if.resp_ready = 1'b1;
    wait_count0("t4_drain", 400);
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    check("t4_full_clear", 32'(bus_if.req_full), 32'd0);
    sync();

    // Cycle counter wrap during the response latency.
    force dut.now_q = 32'hFFFF_FFF0;
    sync();
    release dut.now_q;
    send(ASE_TX1_WRLINE, 16'h0055, 1'b1);
    wait_valid("t5_wait", 40, n);
    check("t5_wrap_latency", 32'(n), 32'd21);
    repeat (3) sync();

    // Asynchronous reset while presenting with 5 pending entries.
    bus_if.resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(ASE_TX1_WRLINE, 16'h0061 + 16'(i), 1'b1);
    wait_valid("t6_wait", 40, n);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid_drop", 32'(bus_if.resp_valid), 32'd0);
    check("t6_async_count", 32'(count), 32'd0);
    exp_q.delete();
    repeat (2) sync();
    rst_n = 1'b1;
    check("t6_overflow_cleared", 32'(overflow), 32'd0);
    check("t6_mdata_cleared", 32'(bus_if.resp_mdata), 32'd0);
    bus_if.resp_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.resp_valid) bad++;
    end
    check("t6_no_stale", 32'(bad), 32'd0);
    sync();
    send(ASE_TX1_WRLINE, 16'h0077, 1'b1);
    wait_valid("t6_post_wait", 40, n);
    check("t6_post_latency", 32'(n), 32'd21);
    repeat (5) sync();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_underflow", 32'(underflow), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
